// File: rtl/i2s_receiver_if.sv
// Frame read port of the I2S receiver: FWFT head frame, valid, pop and level.
// The master side (the receiver) presents frames; the slave side pops them.
interface i2s_receiver_if #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [2*DATA_W-1:0] data_out;
    logic                data_valid;
    logic                data_rd;
    logic [LW-1:0]       fifo_level;

    modport master (
        output data_out,
        output data_valid,
        output fifo_level,
        input  data_rd
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  fifo_level,
        output data_rd
    );
endinterface

// File: rtl/i2s_receiver.sv
// I2S record-path deserializer: oversamples BCLK/WCLK/SDATA on clk and
// queues {left, right} frames in a first-word-fall-through FIFO.
module i2s_receiver #(
    parameter int DATA_W      = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           i2s_bclk,
    input  logic           i2s_wclk,
    input  logic           i2s_sdata,
    i2s_receiver_if.master rd,
    output logic           overflow,
    output logic           frame_err,
    input  logic           clear_status
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        LEFT,
        RIGHT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] bclk_sync, wclk_sync, sdata_sync;
    logic bclk_prev, bedge, ws, sd, ws_prev;
    logic boundary;

    logic [5:0]        bit_cnt;
    logic [6:0]        bit_n;
    logic              short_word;
    logic [DATA_W-1:0] shift_q, shift_nxt, left_q;
    logic              latch_left, frame_done, word_err;
    logic              push_q;
    logic [FW-1:0]     push_data;

    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          valid, full, do_pop, do_push, drop;

    // bedge, ws and sd are registered together so they stay aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync  <= '0;
            wclk_sync  <= '0;
            sdata_sync <= '0;
            bclk_prev  <= 1'b0;
            bedge      <= 1'b0;
            ws         <= 1'b0;
            sd         <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            wclk_sync  <= {wclk_sync[SYNC_STAGES-2:0], i2s_wclk};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], i2s_sdata};
            bclk_prev  <= bclk_sync[SYNC_STAGES-1];
            bedge      <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
            ws         <= wclk_sync[SYNC_STAGES-1];
            sd         <= sdata_sync[SYNC_STAGES-1];
        end
    end

    assign boundary   = bedge && (ws != ws_prev);
    assign bit_n      = {1'b0, bit_cnt} + 7'd1;
    assign short_word = bit_n < 7'(DATA_W);

    // Bit n (1 = MSB) lands at position DATA_W-n; later bits fall off
    always_comb begin
        shift_nxt = shift_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(bit_n) == DATA_W - i) shift_nxt[i] = sd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        latch_left = 1'b0;
        frame_done = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT_SYNC;
                WAIT_SYNC: begin
                    if (boundary && !ws) state_d = LEFT;
                end
                LEFT: begin
                    if (boundary && ws) begin
                        latch_left = 1'b1;
                        state_d    = RIGHT;
                    end
                end
                RIGHT: begin
                    if (boundary && !ws) begin
                        frame_done = 1'b1;
                        state_d    = LEFT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign word_err = (latch_left | frame_done) & short_word;

    // The boundary bit still belongs to the word that just ended
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_prev   <= 1'b0;
            shift_q   <= '0;
            bit_cnt   <= '0;
            left_q    <= '0;
            push_q    <= 1'b0;
            push_data <= '0;
            frame_err <= 1'b0;
        end else begin
            if (bedge) ws_prev <= ws;
            if (state_q == IDLE) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end else if (bedge) begin
                if (boundary) begin
                    shift_q <= '0;
                    bit_cnt <= '0;
                end else begin
                    shift_q <= shift_nxt;
                    if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
                end
            end
            if (latch_left) left_q <= shift_nxt;
            push_q <= frame_done;
            if (frame_done) push_data <= {left_q, shift_nxt};
            frame_err <= word_err | (frame_err & ~clear_status);
        end
    end

    assign valid   = (count != '0);
    assign full    = (count == LW'(FIFO_DEPTH));
    assign do_pop  = rd.data_rd && valid;
    assign do_push = push_q && (!full || do_pop);
    assign drop    = push_q && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            overflow <= drop | (overflow & ~clear_status);
        end
    end

    assign rd.data_valid = valid;
    assign rd.fifo_level = count;
    assign rd.data_out   = valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: drives I2S frames and checks the FIFO output
// against a frame-level queue model.
module tb_i2s_receiver;
    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int FW    = 2 * DW;

    logic clk = 1'b0;
    logic reset, enable, clear_status;
    logic i2s_bclk, i2s_wclk, i2s_sdata;
    logic overflow, frame_err;

    i2s_receiver_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) rd_if ();

    i2s_receiver #(
        .DATA_W(DW),
        .FIFO_DEPTH(DEPTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .i2s_bclk(i2s_bclk),
        .i2s_wclk(i2s_wclk),
        .i2s_sdata(i2s_sdata),
        .rd(rd_if.master),
        .overflow(overflow),
        .frame_err(frame_err),
        .clear_status(clear_status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [FW-1:0] q[$];
    logic [FW-1:0] pend_frame;
    logic exp_ovf, exp_err, pend_valid, pend_err, prev_bit, rd_on_push;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Captured word: first DW serial bits, left-justified and zero-padded
    function automatic logic [DW-1:0] just(input logic [63:0] w,
                                           input int len);
        if (len >= DW) return DW'(w >> (len - DW));
        return DW'(w << (DW - len));
    endfunction

    function automatic logic [63:0] rnd_word(input int len);
        logic [63:0] v;
        v = {$urandom, $urandom};
        if (len < 64) v = v & ((64'd1 << len) - 64'd1);
        return v;
    endfunction

    // One BCLK period; on a 1->0 word-select boundary the frame completion
    // latency (write at E+1, visible at E+2) is checked against the model.
    task automatic tick(input logic ws, input logic sd, input bit bnd);
        int lvl0;
        i2s_bclk  = 1'b0;
        i2s_wclk  = ws;
        i2s_sdata = sd;
        repeat (4) @(negedge clk);
        i2s_bclk = 1'b1;
        lvl0 = q.size();
        repeat (4) @(negedge clk);
        if (bnd) begin
            chk("level_e1", rd_if.fifo_level, lvl0);
            if (pend_valid) begin
                if (lvl0 == DEPTH && rd_on_push) begin
                    chk("head_swap", rd_if.data_out, q[0]);
                    rd_if.data_rd = 1'b1;
                    void'(q.pop_front());
                    q.push_back(pend_frame);
                end else if (lvl0 == DEPTH) begin
                    exp_ovf = 1'b1;
                end else begin
                    q.push_back(pend_frame);
                end
                if (pend_err) exp_err = 1'b1;
                pend_valid = 1'b0;
            end
            rd_on_push = 1'b0;
            @(negedge clk);
            rd_if.data_rd = 1'b0;
            chk("level_e2", rd_if.fifo_level, q.size());
            chk("valid_e2", rd_if.data_valid, q.size() != 0);
            if (q.size() != 0) chk("head_e2", rd_if.data_out, q[0]);
            chk("ovf_flag", overflow, exp_ovf);
            chk("err_flag", frame_err, exp_err);
        end
    endtask

    task automatic send_word(input logic ws, input logic [63:0] w,
                             input int len, input int en_idx,
                             input logic en_val);
        for (int i = 0; i < len; i++) begin
            if (i == en_idx) enable = en_val;
            tick(ws, prev_bit, (i == 0) && !ws);
            prev_bit = w[len-1-i];
        end
    endtask

    task automatic send_frame(input logic [63:0] l, input logic [63:0] r,
                              input int len);
        send_word(1'b0, l, len, -1, 1'b0);
        send_word(1'b1, r, len, -1, 1'b0);
        pend_frame = {just(l, len), just(r, len)};
        pend_err   = (len < DW);
        pend_valid = 1'b1;
    endtask

    task automatic flush();
        tick(1'b0, prev_bit, 1'b1);
    endtask

    task automatic start_seq();
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        prev_bit = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
    endtask

    task automatic read_all();
        while (q.size() != 0) begin
            chk("rd_valid", rd_if.data_valid, 1'b1);
            chk("rd_data", rd_if.data_out, q[0]);
            chk("rd_level", rd_if.fifo_level, q.size());
            rd_if.data_rd = 1'b1;
            @(negedge clk);
            rd_if.data_rd = 1'b0;
            void'(q.pop_front());
        end
        chk("empty_valid", rd_if.data_valid, 1'b0);
        chk("empty_level", rd_if.fifo_level, 0);
    endtask

    task automatic clear_flags();
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        exp_ovf = 1'b0;
        exp_err = 1'b0;
        chk("clr_ovf", overflow, 1'b0);
        chk("clr_err", frame_err, 1'b0);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int lens[8];
        int len, nf;
        logic [63:0] l, r;
        lens = '{32, 24, 25, 20, 63, 1, 2, 48};
        reset = 1'b1;
        enable = 1'b0;
        clear_status = 1'b0;
        i2s_bclk = 1'b0;
        i2s_wclk = 1'b0;
        i2s_sdata = 1'b0;
        rd_if.data_rd = 1'b0;
        prev_bit = 1'b0;
        pend_valid = 1'b0;
        pend_err = 1'b0;
        pend_frame = '0;
        rd_on_push = 1'b0;
        exp_ovf = 1'b0;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_data", rd_if.data_out, 0);
        chk("rst_valid", rd_if.data_valid, 1'b0);
        chk("rst_level", rd_if.fifo_level, 0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_err", frame_err, 1'b0);

        // standard 64-BCLK frame
        start_seq();
        send_frame(64'hA5A5A5 << 8, 64'h5A5A5A << 8, 32);
        flush();
        chk("std_frame", rd_if.data_out, 48'hA5A5A55A5A5A);
        read_all();

        // enable rises halfway through a right word
        enable = 1'b0;
        repeat (3) @(negedge clk);
        send_word(1'b0, rnd_word(32), 32, -1, 1'b0);
        send_word(1'b1, rnd_word(32), 32, 16, 1'b1);
        send_frame(rnd_word(32), rnd_word(32), 32);
        flush();
        read_all();

        // overflow with five frames and no reads
        start_seq();
        for (int k = 1; k <= 5; k++) send_frame(64'(k) << 8, 64'(k) << 8, 32);
        flush();
        chk("ovf_level", rd_if.fifo_level, 4);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_head", rd_if.data_out, 48'h000001000001);
        read_all();
        rd_if.data_rd = 1'b1;
        @(negedge clk);
        rd_if.data_rd = 1'b0;
        chk("pop_empty", rd_if.fifo_level, 0);
        clear_flags();

        // short 16-bit words
        start_seq();
        send_frame(64'h1234, 64'hABCD, 16);
        flush();
        chk("short_frame", rd_if.data_out, 48'h123400ABCD00);
        chk("short_err", frame_err, 1'b1);
        read_all();
        clear_flags();

        // full FIFO with pop and push in the same cycle
        start_seq();
        for (int k = 0; k < 5; k++) send_frame(rnd_word(32), rnd_word(32), 32);
        rd_on_push = 1'b1;
        flush();
        chk("swap_level", rd_if.fifo_level, 4);
        chk("swap_ovf", overflow, 1'b0);
        read_all();

        // randomized framing and data
        for (int s = 0; s < 3; s++) begin
            start_seq();
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                len = lens[$urandom_range(0, 7)];
                l = rnd_word(len);
                r = rnd_word(len);
                send_frame(l, r, len);
            end
            flush();
            read_all();
            if (exp_err) clear_flags();
        end

        // enable drops mid-frame with two frames queued
        start_seq();
        send_frame(rnd_word(32), rnd_word(32), 32);
        send_frame(rnd_word(32), rnd_word(32), 32);
        send_word(1'b0, rnd_word(32), 32, 16, 1'b0);
        send_word(1'b1, rnd_word(32), 32, -1, 1'b0);
        flush();
        chk("drop_level", rd_if.fifo_level, 2);

        // reset mid-left-word
        start_seq();
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_data", rd_if.data_out, 0);
        chk("mid_rst_valid", rd_if.data_valid, 1'b0);
        chk("mid_rst_level", rd_if.fifo_level, 0);
        chk("mid_rst_ovf", overflow, 1'b0);
        chk("mid_rst_err", frame_err, 1'b0);
        q.delete();
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
